imem_loader: RTL and testbench

- Writer side of the CPU instruction memory. The single-cycle core only ever reads that memory (byte address PC[7:0], 32-bit word out).
- This block accepts a byte stream over a valid/ready handshake, packs every 4 bytes into one 32-bit instruction and writes the words sequentially into the instruction memory write port.
- Holds the CPU (cpu_hold) while a load is in progress, so the core boots the new program on release.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_word_packer.sv | 31 +++
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// byte-lane index width and the maximum word count derived from the address width.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    // Four byte lanes per 32-bit instruction word.
    localparam int                LANE_W    = 2;
    localparam logic [LANE_W-1:0] LANE_LAST = '1;

    // A byte-addressed memory of 2^addr_w bytes holds 2^(addr_w-2) words.
    function automatic int max_words(input int addr_w);
        return 1 << (addr_w - 2);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a stream of bytes big-endian into 32-bit words. word_full flags the
// strobe that captures the 4th byte; the complete word is on 'word' the next cycle.
module imem_loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic        word_full,
    output logic [31:0] word
);

    logic [LANE_W-1:0] lane;

    // Lane counter and shift register; earlier bytes migrate toward [31:24].
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane <= '0;
            word <= '0;
        end else if (accept) begin
            lane <= lane + LANE_W'(1);
            word <= {word[23:0], byte_in};
        end
    end

    assign word_full = accept && (lane == LANE_LAST);

endmodule

// File: rtl/imem_loader.sv
// Writer side of the CPU instruction memory: takes a count byte followed by
// 4*N program bytes, writes N words sequentially and holds the core meanwhile.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = max_words(ADDR_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-2:0] words_loaded
);

    localparam int                CNT_W   = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    state_t            state;
    logic [CNT_W-1:0]  word_count;
    logic [31:0]       wdata_hold;
    logic [31:0]       pk_word;
    logic [ADDR_W-1:0] next_addr;
    logic              xfer;
    logic              active;
    logic              start_ok;
    logic              count_ok;
    logic              go_err;
    logic              pk_accept;
    logic              pk_full;

    assign xfer      = byte_valid && byte_ready;
    assign active    = (state == S_COUNT) || (state == S_DATA) || (state == S_WRITE);
    assign start_ok  = start && !active;
    assign count_ok  = (byte_in != 8'd0) && (int'(byte_in) <= MAX_WORDS);
    // A byte taken in the same cycle as abort is dropped.
    assign pk_accept = xfer && (state == S_DATA) && !abort;
    assign go_err    = (active && abort) || ((state == S_COUNT) && xfer && !count_ok);
    // Address arithmetic wraps modulo 2^ADDR_W on purpose.
    assign next_addr = BASE + {words_loaded[ADDR_W-3:0], 2'b00};

    // The write strobe is gated combinationally so an abort or reset in the
    // WRITE cycle itself still prevents the memory from being written.
    assign im_we    = (state == S_WRITE) && !abort && !rst;
    // The packer's register holds the finished word during WRITE; afterwards the
    // last written word is held so the data bus stays stable outside WRITE.
    assign im_wdata = (state == S_WRITE) ? pk_word : wdata_hold;

    imem_loader_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .accept    (pk_accept),
        .byte_in   (byte_in),
        .word_full (pk_full),
        .word      (pk_word)
    );

    // Session FSM with registered handshake/status outputs and word counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            byte_ready   <= 1'b0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            word_count   <= '0;
            im_addr      <= '0;
            wdata_hold   <= '0;
        end else if (go_err) begin
            state      <= S_ERR;
            err        <= 1'b1;
            cpu_hold   <= 1'b0;
            byte_ready <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state        <= S_COUNT;
                        byte_ready   <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        words_loaded <= '0;
                    end
                end
                S_COUNT: begin
                    if (xfer) begin
                        word_count <= CNT_W'(byte_in);
                        state      <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (pk_full) begin
                        state      <= S_WRITE;
                        byte_ready <= 1'b0;
                        im_addr    <= next_addr;
                    end
                end
                S_WRITE: begin
                    wdata_hold   <= pk_word;
                    words_loaded <= words_loaded + CNT_ONE;
                    if (words_loaded + CNT_ONE == word_count) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state      <= S_DATA;
                        byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                    cpu_hold   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: two instances (base 0x00 and base 0xF8)
// share one stimulus stream; writes are logged and compared to a word list
// computed directly from the byte stream.
module tb_imem_loader;

    typedef logic [7:0] byteq_t[$];

    localparam int BASE_A = 0;
    localparam int BASE_B = 248;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        a_byte_ready, a_im_we, a_cpu_hold, a_done, a_err;
    logic [7:0]  a_im_addr;
    logic [31:0] a_im_wdata;
    logic [6:0]  a_words_loaded;
    logic        b_byte_ready, b_im_we, b_cpu_hold, b_done, b_err;
    logic [7:0]  b_im_addr;
    logic [31:0] b_im_wdata;
    logic [6:0]  b_words_loaded;

    int vectors    = 0;
    int miscompares = 0;

    logic [39:0] a_log[$];
    logic [39:0] b_log[$];
    byteq_t      bs;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8), .BASE_ADDR(BASE_A)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(a_byte_ready),
        .im_we(a_im_we), .im_addr(a_im_addr), .im_wdata(a_im_wdata),
        .cpu_hold(a_cpu_hold), .done(a_done), .err(a_err), .words_loaded(a_words_loaded)
    );

    imem_loader #(.ADDR_W(8), .BASE_ADDR(BASE_B)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(b_byte_ready),
        .im_we(b_im_we), .im_addr(b_im_addr), .im_wdata(b_im_wdata),
        .cpu_hold(b_cpu_hold), .done(b_done), .err(b_err), .words_loaded(b_words_loaded)
    );

    // Memory-side view: record every write the memory would commit on this edge.
    always @(posedge clk) begin
        if (a_im_we) a_log.push_back({a_im_addr, a_im_wdata});
        if (b_im_we) b_log.push_back({b_im_addr, b_im_wdata});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic byteq_t make_load(input int n);
        byteq_t q;
        q.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Reference: word w is bytes 4w+1..4w+4 big-endian at base + 4w (mod 256).
    task automatic verify_writes(input string tag, input byteq_t q, input int nwords);
        logic [31:0] word;
        logic [7:0]  ea;
        logic [7:0]  eb;
        check({tag, "_count_a"}, 64'(a_log.size()), 64'(nwords));
        check({tag, "_count_b"}, 64'(b_log.size()), 64'(nwords));
        for (int w = 0; w < nwords; w++) begin
            word = {q[1+4*w], q[2+4*w], q[3+4*w], q[4+4*w]};
            ea   = 8'((BASE_A + 4 * w) % 256);
            eb   = 8'((BASE_B + 4 * w) % 256);
            if (w < a_log.size()) check({tag, "_write_a"}, a_log[w], {ea, word});
            if (w < b_log.size()) check({tag, "_write_b"}, b_log[w], {eb, word});
        end
        a_log.delete();
        b_log.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_byte_ready"}, a_byte_ready, 0);
        check({tag, "_im_we"}, {a_im_we, b_im_we}, 0);
        check({tag, "_im_addr"}, {a_im_addr, b_im_addr}, 0);
        check({tag, "_im_wdata"}, {a_im_wdata, b_im_wdata}, 0);
        check({tag, "_cpu_hold"}, a_cpu_hold, 0);
        check({tag, "_done"}, a_done, 0);
        check({tag, "_err"}, a_err, 0);
        check({tag, "_words_loaded"}, a_words_loaded, 0);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check({tag, "_start_hold"}, a_cpu_hold, 1);
        check({tag, "_start_ready"}, a_byte_ready, 1);
        check({tag, "_start_status"}, {a_done, a_err, a_words_loaded}, 0);
    endtask

    task automatic check_end(input string tag, input logic exp_done, input logic exp_err,
                             input int exp_words);
        check({tag, "_done"}, a_done, exp_done);
        check({tag, "_err"}, {a_err, b_err}, {exp_err, exp_err});
        check({tag, "_cpu_hold"}, a_cpu_hold, 0);
        check({tag, "_byte_ready"}, a_byte_ready, 0);
        check({tag, "_words_loaded"}, a_words_loaded, 64'(exp_words));
    endtask

    // Offer bytes from q; abort_at/start_at pulse abort/start while byte idx is offered;
    // kill_mode 1 = abort, 2 = rst during the WRITE cycle of word kill_word.
    task automatic stream(input string tag, input byteq_t q, input bit gaps, input int abort_at,
                          input int start_at, input int kill_mode, input int kill_word);
        int idx      = 0;
        int cyc      = 0;
        int wcount   = 0;
        int limit    = 50 + 10 * q.size();
        bit phase    = 1'b1;
        bit in_write = 1'b0;
        bit stop     = 1'b0;
        bit acc;
        bit ab;
        while (!stop && (idx < q.size() || in_write) && cyc < limit) begin
            byte_valid = (idx < q.size()) && (!gaps || phase);
            phase      = !phase;
            byte_in    = (idx < q.size()) ? q[idx] : 8'h00;
            abort      = (idx == abort_at);
            start      = (idx == start_at);
            ab         = abort;
            acc        = byte_valid && a_byte_ready;
            cycle();
            cyc++;
            byte_valid = 1'b0;
            abort      = 1'b0;
            start      = 1'b0;
            if (in_write) begin
                in_write = 1'b0;
                wcount++;
                check({tag, "_words_after_write"}, a_words_loaded, 64'(wcount));
                if (wcount == int'(q[0])) check({tag, "_done_after_last"}, {a_done, a_cpu_hold}, 2'b10);
                else check({tag, "_ready_after_write"}, a_byte_ready, 1);
            end
            if (ab) begin
                stop = 1'b1;
            end else if (acc) begin
                if (idx >= 1 && (idx - 1) % 4 == 3) begin
                    in_write = 1'b1;
                    check({tag, "_we_latency"}, {a_im_we, b_im_we}, 2'b11);
                    check({tag, "_write_cycle_ready"}, a_byte_ready, 0);
                    check({tag, "_write_cycle_hold"}, a_cpu_hold, 1);
                    if (kill_mode != 0 && wcount == kill_word) begin
                        if (kill_mode == 1) abort = 1'b1;
                        else rst = 1'b1;
                        #1;
                        check({tag, "_killed_we"}, {a_im_we, b_im_we}, 0);
                        @(posedge clk);
                        #1;
                        abort    = 1'b0;
                        in_write = 1'b0;
                        stop     = 1'b1;
                    end
                end
                idx++;
            end
        end
        check({tag, "_in_budget"}, stop || (idx >= q.size() && !in_write), 1);
    endtask

    task automatic full_load(input string tag, input byteq_t q, input bit gaps);
        do_start(tag);
        stream(tag, q, gaps, -1, -1, 0, 0);
        check_end(tag, 1'b1, 1'b0, int'(q[0]));
        verify_writes(tag, q, int'(q[0]));
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b1;
        abort      = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        repeat (2) cycle();
        rst        = 1'b0;
        start      = 1'b0;
        check_zero("reset");

        // Bytes offered while idle are not taken.
        repeat (3) begin
            byte_valid = 1'b1;
            cycle();
            check("idle_no_ready", {a_byte_ready, a_cpu_hold}, 0);
        end
        byte_valid = 1'b0;
        a_log.delete();
        b_log.delete();

        // Basic load, then the same stream with source gaps.
        bs = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        full_load("basic", bs, 1'b0);
        full_load("gaps", bs, 1'b1);

        // abort in DONE is ignored.
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("abort_in_done", {a_done, a_err}, 2'b10);

        // Bad counts: zero, one past the maximum, and a random oversize value.
        bs = '{8'h00};
        do_start("cnt0");
        stream("cnt0", bs, 1'b0, -1, -1, 0, 0);
        check_end("cnt0", 1'b0, 1'b1, 0);
        verify_writes("cnt0", bs, 0);
        bs = '{8'h41};
        do_start("cnt65");
        stream("cnt65", bs, 1'b0, -1, -1, 0, 0);
        check_end("cnt65", 1'b0, 1'b1, 0);
        verify_writes("cnt65", bs, 0);
        bs = '{8'($urandom_range(65, 255))};
        do_start("cnt_big");
        stream("cnt_big", bs, 1'b0, -1, -1, 0, 0);
        check_end("cnt_big", 1'b0, 1'b1, 0);
        verify_writes("cnt_big", bs, 0);

        // Abort after 2 of 3 words plus one byte; abort beats the byte offered with it.
        bs = make_load(3);
        do_start("abort");
        stream("abort", bs, 1'b0, 10, -1, 0, 0);
        repeat (2) cycle();
        check_end("abort", 1'b0, 1'b1, 2);
        verify_writes("abort", bs, 2);

        // Restart after an error with a single word.
        bs = make_load(1);
        full_load("restart", bs, 1'b0);

        // start during DATA is ignored.
        bs = make_load(2);
        do_start("start_mid");
        stream("start_mid", bs, 1'b0, -1, 3, 0, 0);
        check_end("start_mid", 1'b1, 1'b0, 2);
        verify_writes("start_mid", bs, 2);

        // abort in the WRITE cycle of the second word: only one word lands.
        bs = make_load(3);
        do_start("abort_write");
        stream("abort_write", bs, 1'b0, -1, -1, 1, 1);
        check_end("abort_write", 1'b0, 1'b1, 1);
        verify_writes("abort_write", bs, 1);

        // rst in the first WRITE cycle: nothing written, everything cleared.
        bs = make_load(2);
        do_start("rst_write");
        stream("rst_write", bs, 1'b0, -1, -1, 2, 0);
        check_zero("rst_write");
        rst = 1'b0;
        cycle();
        verify_writes("rst_write", bs, 0);

        // Three words: instance B wraps 0xF8, 0xFC, 0x00.
        bs = make_load(3);
        full_load("wrap", bs, 1'b0);

        // start+abort together: start wins when idle-like, abort wins when active.
        start = 1'b1;
        abort = 1'b1;
        cycle();
        check("start_abort_done", {a_cpu_hold, a_err, a_done}, 3'b100);
        cycle();
        check("start_abort_count", {a_cpu_hold, a_err}, 2'b01);
        start = 1'b0;
        abort = 1'b0;
        cycle();
        verify_writes("start_abort", bs, 0);

        // Randomized loads with random gap patterns, then a maximum-size load.
        for (int r = 0; r < 5; r++) begin
            bs = make_load(int'($urandom_range(1, 10)));
            full_load("random", bs, 1'($urandom_range(0, 1)));
        end
        bs = make_load(64);
        full_load("max", bs, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
